hamming_decoder: RTL and testbench
==================================

Name: hamming_decoder

Overview:
- Hardware SECDED decoder stage that consumes the 16-bit parity-embedded codewords produced by the program-1 encoder in data memory.
- On req, walks NUM_WORDS codewords stored little-endian at SRC_BASE, and for each one corrects any single-bit error and detects double errors.
- Writes the 11-bit message plus a 2-bit error flag back to DST_BASE.
- Owns the data-memory byte port while busy.

Parameters:
- NUM_WORDS, 15, number of codewords processed per run (1..127).
- SRC_BASE, 30, byte address of the first codeword's low byte.
- DST_BASE, 0, byte address of the first decoded word's low byte.
- AW, 8, memory byte-address width.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  start pulse, sampled only in IDLE.
- done  output  1  run complete, level.
- mem_addr  output  AW  byte address.
- mem_rd_data  input  8  combinational read data for mem_addr, same cycle.
- mem_wr_en  output  1  write strobe, byte written at rising edge.
- mem_wr_data  output  8  write data.
- err1_count  output  8  codewords corrected (single error) this run.
- err2_count  output  8  codewords flagged uncorrectable this run.

Behaviour:

Reset:
- done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, both counts=0, word index i=0, state=IDLE.
- Reset asserted mid-run aborts immediately. Writes already performed remain in memory; no further writes occur.

Codeword layout (cw = {hi,lo}):
- cw[15:0] = {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
- Hamming position k (1..15) is cw[k]; p0 = cw[0] is overall parity.

Decode:
- syndrome s[3:0] = XOR of k over all k in 1..15 with cw[k]=1.
- P = ^cw[15:0].
- P=0, s=0: flag 00, no change.
- P=1: flag 01, flip cw[s] when s!=0; s=0 means the error is in p0 and the data is unchanged.
- P=0, s!=0: flag 10, data emitted uncorrected from raw cw.
- Output hi byte = {flag[1:0], 3'b000, d11, d10, d9}; lo byte = d8..d1.

FSM, one memory access per cycle:
- IDLE: done holds its last value. When req=1, go to RD_LO next cycle with i=0, done=0, counts=0. In every other state req is ignored.
- RD_LO: mem_addr = SRC_BASE+2i; latch lo byte.
- RD_HI: mem_addr = SRC_BASE+2i+1; decode combinationally from latched lo and live mem_rd_data. Register the output bytes and flag.
- RD_HI counter update: increment err1_count (flag 01) or err2_count (flag 10). Counters saturate at 255.
- WR_LO: mem_addr = DST_BASE+2i, mem_wr_en=1, data = decoded lo.
- WR_HI: mem_addr = DST_BASE+2i+1, mem_wr_en=1, data = decoded hi. If i==NUM_WORDS-1, go to DONE; otherwise i+1 and go to RD_LO.
- DONE: done=1 for one cycle into IDLE, then stays 1 in IDLE until the next req is accepted.

Timing and memory port:
- Latency: exactly 4 cycles per word. done rises 4*NUM_WORDS+1 cycles after the cycle req is sampled (61 for defaults).
- mem_wr_en is high only in WR_LO/WR_HI.
- mem_addr is held at its last value in IDLE/DONE.
- Address arithmetic is modulo 2^AW.
- Overlapping source and destination ranges are legal. Each word is fully read before it is written, so in-place decode (SRC_BASE==DST_BASE) works.

Test Plan:
- Clean word: bytes 30/31 = 8'h2D/8'hB4 (cw 16'hB42D, data 11'h5A3), NUM_WORDS=1, pulse req -> mem[0]=8'hA3, mem[1]=8'h05, err1=0, err2=0; done rises 5 cycles after req is sampled.
- Single data error: lo=8'h6D (bit 6 flipped) -> mem[0]=8'hA3, mem[1]=8'h45, err1_count=1.
- p0-only error: lo=8'h2C -> mem[0]=8'hA3, mem[1]=8'h45, err1=1.
- Double error: lo=8'h6F (bits 6 and 1 flipped) -> mem[0]=8'hA7, mem[1]=8'h85, err2_count=1, err1=0.
- Full run: 15 random 11-bit messages encoded by the reference model, each with 0/1/2 random flips, stored at bytes 30..59.
  - Required: all 30 output bytes match the model and counts match the injected tallies.
  - Required: done rises exactly 61 cycles after req.
  - Required: req pulses during the run have no effect.
- Async reset at cycle 20 of a run -> all outputs 0 within the same cycle, no writes after reset, later req restarts cleanly from i=0 with correct results.

Source files
------------

// File: rtl/hamming_decoder.sv
// SECDED decoder stage: reads 16-bit codewords from byte memory, corrects single errors,
// flags double errors and writes the 11-bit message plus a 2-bit flag back to memory.
module hamming_decoder #(
  parameter int unsigned NUM_WORDS = 15,
  parameter int unsigned SRC_BASE  = 30,
  parameter int unsigned DST_BASE  = 0,
  parameter int unsigned AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [7:0]    err1_count,
  output logic [7:0]    err2_count
);

  typedef enum logic [2:0] {StIdle, StRdLo, StRdHi, StWrLo, StWrHi, StDone} state_e;

  state_e        state_q, state_d;
  logic [6:0]    idx_q, idx_d;
  logic          done_q, done_d;
  logic [7:0]    err1_q, err1_d;
  logic [7:0]    err2_q, err2_d;
  logic [7:0]    lo_q;
  logic [7:0]    out_lo_q, out_hi_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] src_addr, dst_addr;
  logic          last_word;

  logic [15:0]   cw;
  logic [3:0]    syn;
  logic          par, fix;
  logic [10:0]   dat;
  logic [1:0]    flag;
  logic [7:0]    dec_lo, dec_hi;

  assign src_addr  = AW'(SRC_BASE + (32'(idx_q) << 1));
  assign dst_addr  = AW'(DST_BASE + (32'(idx_q) << 1));
  assign last_word = (idx_q == 7'(NUM_WORDS - 1));

  // Decode from the latched low byte and the live high byte.
  always_comb begin
    cw  = {mem_rd_data, lo_q};
    syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (cw[k]) syn = syn ^ 4'(k);
    end
    par = ^cw;
    fix = par && (syn != 4'd0);
    dat = {cw[15:9], cw[7:5], cw[3]};
    if (fix) begin
      case (syn)
        4'd3:    dat[0]  = ~dat[0];
        4'd5:    dat[1]  = ~dat[1];
        4'd6:    dat[2]  = ~dat[2];
        4'd7:    dat[3]  = ~dat[3];
        4'd9:    dat[4]  = ~dat[4];
        4'd10:   dat[5]  = ~dat[5];
        4'd11:   dat[6]  = ~dat[6];
        4'd12:   dat[7]  = ~dat[7];
        4'd13:   dat[8]  = ~dat[8];
        4'd14:   dat[9]  = ~dat[9];
        4'd15:   dat[10] = ~dat[10];
        default: ; // parity-bit position: data already correct
      endcase
    end
    if (par) begin
      flag = 2'b01;
    end else if (syn != 4'd0) begin
      flag = 2'b10;
    end else begin
      flag = 2'b00;
    end
    dec_lo = dat[7:0];
    dec_hi = {flag, 3'b000, dat[10:8]};
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_d      = done_q;
    err1_d      = err1_q;
    err2_d      = err2_q;
    mem_addr    = addr_q;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StRdLo;
          idx_d   = 7'd0;
          done_d  = 1'b0;
          err1_d  = 8'd0;
          err2_d  = 8'd0;
        end
      end
      StRdLo: begin
        mem_addr = src_addr;
        state_d  = StRdHi;
      end
      StRdHi: begin
        mem_addr = src_addr + AW'(1);
        state_d  = StWrLo;
        if (flag == 2'b01 && err1_q != 8'hff) err1_d = err1_q + 8'd1;
        if (flag == 2'b10 && err2_q != 8'hff) err2_d = err2_q + 8'd1;
      end
      StWrLo: begin
        mem_addr    = dst_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = out_lo_q;
        state_d     = StWrHi;
      end
      StWrHi: begin
        mem_addr    = dst_addr + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = out_hi_q;
        if (last_word) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 7'd1;
          state_d = StRdLo;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= 7'd0;
      done_q   <= 1'b0;
      err1_q   <= 8'd0;
      err2_q   <= 8'd0;
      lo_q     <= 8'd0;
      out_lo_q <= 8'd0;
      out_hi_q <= 8'd0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err1_q  <= err1_d;
      err2_q  <= err2_d;
      addr_q  <= mem_addr;
      if (state_q == StRdLo) lo_q <= mem_rd_data;
      if (state_q == StRdHi) begin
        out_lo_q <= dec_lo;
        out_hi_q <= dec_hi;
      end
    end
  end

  assign done       = done_q;
  assign err1_count = err1_q;
  assign err2_count = err2_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: a 1-word instance for directed codewords and a 15-word instance
// for random runs, mid-run reset and restart; writes are checked by a scoreboard monitor.
module tb_hamming_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] LO_TAB [4] = '{8'h2D, 8'h6D, 8'h2C, 8'h6F};
  localparam logic [7:0] EXP_LO [4] = '{8'hA3, 8'hA3, 8'hA3, 8'hA7};
  localparam logic [7:0] EXP_HI [4] = '{8'h05, 8'h45, 8'h45, 8'h85};
  localparam logic [7:0] EXP_E1 [4] = '{8'd0, 8'd1, 8'd1, 8'd0};
  localparam logic [7:0] EXP_E2 [4] = '{8'd0, 8'd0, 8'd0, 8'd1};

  logic       rst_a, req_a, done_a, we_a, ld_a;
  logic [7:0] addr_a, rd_a, wd_a, e1_a, e2_a, ld_addr_a, ld_data_a;
  logic [7:0] mem_a [256];
  logic       rst_b, req_b, done_b, we_b, ld_b;
  logic [7:0] addr_b, rd_b, wd_b, e1_b, e2_b, ld_addr_b, ld_data_b;
  logic [7:0] mem_b [256];

  logic [15:0] q_a [$];
  logic [15:0] q_b [$];
  logic        sb_en_b = 1'b1;
  logic        watch_b = 1'b0;
  int          stray_b = 0;
  int          t1, t2;
  logic [7:0]  exp_b [30];

  hamming_decoder #(.NUM_WORDS(1)) dut_a (
    .clk(clk), .reset(rst_a), .req(req_a), .done(done_a), .mem_addr(addr_a),
    .mem_rd_data(rd_a), .mem_wr_en(we_a), .mem_wr_data(wd_a),
    .err1_count(e1_a), .err2_count(e2_a)
  );

  hamming_decoder dut_b (
    .clk(clk), .reset(rst_b), .req(req_b), .done(done_b), .mem_addr(addr_b),
    .mem_rd_data(rd_b), .mem_wr_en(we_b), .mem_wr_data(wd_b),
    .err1_count(e1_b), .err2_count(e2_b)
  );

  assign rd_a = mem_a[addr_a];
  assign rd_b = mem_b[addr_b];

  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= wd_a;
    else if (ld_a) mem_a[ld_addr_a] <= ld_data_a;
    if (we_b) mem_b[addr_b] <= wd_b;
    else if (ld_b) mem_b[ld_addr_b] <= ld_data_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard monitor: every write must match the next expected {addr, data}.
  always @(negedge clk) begin
    logic [15:0] e;
    if (we_a) begin
      if (q_a.size() == 0) fail("a_unexpected_write");
      else begin
        e = q_a.pop_front();
        check("a_write", {addr_a, wd_a}, e);
      end
    end
    if (we_b) begin
      if (watch_b) stray_b++;
      else if (sb_en_b) begin
        if (q_b.size() == 0) fail("b_unexpected_write");
        else begin
          e = q_b.pop_front();
          check("b_write", {addr_b, wd_b}, e);
        end
      end
    end
  end

  function automatic logic [15:0] encode(input logic [10:0] msg);
    logic [15:0] cw;
    int          j;
    logic        b;
    cw = '0;
    j  = 0;
    for (int k = 3; k < 16; k++) begin
      if (k != 4 && k != 8) begin
        cw[k] = msg[j];
        j++;
      end
    end
    for (int p = 1; p < 16; p = p << 1) begin
      b = 1'b0;
      for (int k = 1; k < 16; k++) begin
        if ((k & p) != 0 && k != p) b = b ^ cw[k];
      end
      cw[p] = b;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] cw);
    logic [10:0] d;
    int          j;
    d = '0;
    j = 0;
    for (int k = 3; k < 16; k++) begin
      if (k != 4 && k != 8) begin
        d[j] = cw[k];
        j++;
      end
    end
    return d;
  endfunction

  task automatic load_a(input logic [7:0] a, input logic [7:0] d);
    ld_a = 1'b1; ld_addr_a = a; ld_data_a = d;
    @(posedge clk);
    #1 ld_a = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] a, input logic [7:0] d);
    ld_b = 1'b1; ld_addr_b = a; ld_data_b = d;
    @(posedge clk);
    #1 ld_b = 1'b0;
  endtask

  task automatic run_a(output int lat);
    req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 400) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  // Extra req pulses mid-run must be ignored.
  task automatic run_b(output int lat);
    req_b = 1'b1;
    @(posedge clk);
    #1 req_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 400) begin
      req_b = (lat == 7 || lat == 25 || lat == 50);
      @(posedge clk);
      #1 lat++;
    end
    req_b = 1'b0;
  endtask

  // Random messages with 0, 1 or 2 injected flips; expectations follow from the injection.
  task automatic prep_b();
    logic [10:0] msg, dat;
    logic [15:0] cw, bad;
    logic [7:0]  lo, hi;
    int          n, p1, p2;
    t1 = 0;
    t2 = 0;
    p1 = 0;
    for (int w = 0; w < 15; w++) begin
      msg = 11'($urandom);
      cw  = encode(msg);
      n   = $urandom_range(0, 2);
      bad = cw;
      if (n >= 1) begin
        p1 = $urandom_range(0, 15);
        bad[p1] = ~bad[p1];
      end
      if (n == 2) begin
        do p2 = $urandom_range(0, 15); while (p2 == p1);
        bad[p2] = ~bad[p2];
      end
      dat = (n == 2) ? extract(bad) : msg;
      if (n == 1) t1++;
      if (n == 2) t2++;
      lo = dat[7:0];
      hi = {2'(n), 3'b000, dat[10:8]};
      exp_b[2*w]   = lo;
      exp_b[2*w+1] = hi;
      load_b(8'(30 + 2*w), bad[7:0]);
      load_b(8'(31 + 2*w), bad[15:8]);
      load_b(8'(2*w), 8'hEE);
      load_b(8'(2*w + 1), 8'hEE);
      q_b.push_back({8'(2*w), lo});
      q_b.push_back({8'(2*w + 1), hi});
    end
  endtask

  task automatic check_run_b(input int lat);
    check("b_latency", lat, 61);
    check("b_err1", e1_b, t1);
    check("b_err2", e2_b, t2);
    for (int i = 0; i < 30; i++) check($sformatf("b_mem%0d", i), mem_b[i], exp_b[i]);
    check("b_pending", q_b.size(), 0);
  endtask

  initial begin
    int lat;
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
    ld_a = 1'b0; ld_b = 1'b0;
    ld_addr_a = '0; ld_data_a = '0; ld_addr_b = '0; ld_data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", {done_a, done_b}, 0);
    check("rst_we", {we_a, we_b}, 0);
    check("rst_addr_a", addr_a, 0);
    check("rst_addr_b", addr_b, 0);
    check("rst_wd", {wd_a, wd_b}, 0);
    check("rst_cnt_a", {e1_a, e2_a}, 0);
    check("rst_cnt_b", {e1_b, e2_b}, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      load_a(8'd30, LO_TAB[i]);
      load_a(8'd31, 8'hB4);
      load_a(8'd0, 8'hEE);
      load_a(8'd1, 8'hEE);
      q_a.push_back({8'd0, EXP_LO[i]});
      q_a.push_back({8'd1, EXP_HI[i]});
      run_a(lat);
      check($sformatf("a%0d_latency", i), lat, 5);
      check($sformatf("a%0d_err1", i), e1_a, EXP_E1[i]);
      check($sformatf("a%0d_err2", i), e2_a, EXP_E2[i]);
      check($sformatf("a%0d_mem0", i), mem_a[0], EXP_LO[i]);
      check($sformatf("a%0d_mem1", i), mem_a[1], EXP_HI[i]);
      check($sformatf("a%0d_pending", i), q_a.size(), 0);
    end

    prep_b();
    run_b(lat);
    check_run_b(lat);

    // Abort a run with reset at cycle 20, then confirm a clean restart.
    sb_en_b = 1'b0;
    prep_b();
    q_b.delete();
    req_b = 1'b1;
    @(posedge clk);
    #1 req_b = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst_b = 1'b1;
    #1;
    check("abort_done", done_b, 0);
    check("abort_we", we_b, 0);
    check("abort_addr", addr_b, 0);
    check("abort_wd", wd_b, 0);
    check("abort_err1", e1_b, 0);
    check("abort_err2", e2_b, 0);
    watch_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    repeat (10) @(posedge clk);
    #1 watch_b = 1'b0;
    check("abort_stray_writes", stray_b, 0);
    sb_en_b = 1'b1;

    prep_b();
    run_b(lat);
    check_run_b(lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
